uart_rx_fifo: RTL
=================

# uart_rx_fifo

Parametrised second-generation UART receiver for the PicoBlaze-style port-mapped I/O system. Supports a run-time clock divisor and 7- or 8-bit data. Parity is optional and odd or even; one or two stop bits. Start bits are validated at mid-bit, so glitches are rejected. Received frames go into a show-ahead FIFO that stores per-entry error flags, so the CPU no longer has to service every byte before the next one arrives.

## Interface
- DIV_W, 20, width of DIVISOR
- FIFO_DEPTH, 8, FIFO entries; power of two, at least 2
- CLK  in  1  system clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- RX  in  1  serial input, asynchronous, idle high
- EIGHT  in  1  1 = 8 data bits, 0 = 7 data bits
- PEN  in  1  parity enable
- OHEL  in  1  parity sense: 1 = odd, 0 = even
- STOP2  in  1  1 = two stop bits checked
- DIVISOR  in  DIV_W  CLK cycles per bit; values below 4 are treated as 4
- port_id  in  4  I/O address: 0 = data, 1 = status
- read_strobe  in  1  one-cycle CPU read qualifier
- UART_DATA  out  8  FIFO head data, combinational; 0x00 when empty
- RX_STATUS  out  8  {3'b0, full, ovf, ferr, perr, rxrdy}

## Operation
- RX passes through a 2-flop synchroniser (reset value 1) to give rxs. All detection uses rxs.
- EIGHT, PEN, OHEL, STOP2 and DIVISOR (clamped) are latched on leaving IDLE and held for the whole frame.
- FSM states and transitions:
  - IDLE: rxs = 0 → START; the bit counter clears.
  - START: wait floor(D/2) cycles, then sample. Sample 1 → IDLE (false start, nothing pushed). Sample 0 → DATA.
  - DATA: sample every D cycles, LSB first. After N samples (N = 8 if EIGHT, else 7), go to PARITY if PEN, otherwise STOP.
  - PARITY: one sample after D cycles. perr_f = sample XOR (XOR of data bits) XOR OHEL. Expected parity makes the total count of ones even, or odd when OHEL = 1.
  - STOP: sample after D cycles; sample 0 sets ferr_f. If STOP2, take a second sample D cycles later; 0 there also sets ferr_f. On the last stop sample: push {ferr_f, perr_f, data} and go to IDLE in the same cycle. The next frame's start may therefore be detected during the second half of the stop bit.
- 7-bit mode: data[7] = 0.
- FIFO entries are 10 bits wide.
  - Push: at frame completion.
  - Pop: read_strobe & port_id == 0 & !empty.
  - Push while full and no pop: frame discarded, ovf set.
  - Push and pop in the same cycle while full: both occur, ovf not set.
  - Pop while empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter is clog2(FIFO_DEPTH)+1 bits.
- RX_STATUS fields:
  - rxrdy = !empty.
  - perr, ferr = flags of the head entry; 0 when empty.
  - full = count == FIFO_DEPTH.
  - ovf is sticky. It is cleared by read_strobe & port_id == 1. A set in the same cycle wins over the clear.
- Reset, including mid-frame: FSM to IDLE, FIFO emptied, ovf = 0, synchroniser = 1, counters = 0.
  - Outputs after reset: UART_DATA = 0x00, RX_STATUS = 0x00.
  - A frame in progress is lost.

## Timing
- Cycle 0 = first cycle rxs = 0 in IDLE; D = latched divisor.
- Start sample at cycle floor(D/2). Data bit i sampled at floor(D/2) + (i+1)·D.
- Push at the last stop sample cycle. FIFO state, rxrdy and UART_DATA update on the next edge.
- Pin-to-rxs latency: 2 cycles.
- Pop: UART_DATA shows the next entry on the cycle after the strobe.
- Baud error tolerance: sampling at mid-bit gives ±(D/2)/(frame bits·D) drift margin.
- No combinational path from RX to any output.

## Test plan
- 8N1, D=16, send 0xA5 → UART_DATA = 0xA5 and RX_STATUS = 0x01 exactly 2+8+9·16+1 cycles after the RX falling edge. Data-port read then gives RX_STATUS = 0x00.
- 7 data bits, even parity, D=10, send 0x41 with parity bit 1 (wrong) → UART_DATA = 0x41, RX_STATUS = 0x03. Same frame with parity 0 → RX_STATUS = 0x01.
- 8N2, D=8, second stop bit driven 0 → RX_STATUS = 0x05 (ferr, rxrdy). A following good frame stored behind it → after one pop, RX_STATUS = 0x01.
- RX low pulse of 3 cycles with D=16 → FSM returns to IDLE, FIFO stays empty, RX_STATUS = 0x00.
- FIFO_DEPTH=4, five 8N1 frames 0x10–0x14 with no reads → full = 1 and ovf = 1 (RX_STATUS = 0x19); reads return 0x10–0x13. A status read clears ovf. A frame completing in the same cycle as a data pop while full → no ovf.
- Assert RESET for one cycle mid-way through the data bits → RX_STATUS = 0x00 and UART_DATA = 0x00 on the next cycle. A subsequent clean frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with a mid-bit validated start, a run-time
// divisor, 7/8 data bits, optional odd/even parity and one or two stop bits.
// Completed frames and their error flags go into a show-ahead FIFO that the
// CPU reads through a two-address port (0 = data, 1 = status).
module uart_rx_fifo #(
  parameter int DIV_W      = 20,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             RX,
  input  logic             EIGHT,
  input  logic             PEN,
  input  logic             OHEL,
  input  logic             STOP2,
  input  logic [DIV_W-1:0] DIVISOR,
  input  logic [3:0]       port_id,
  input  logic             read_strobe,
  output logic [7:0]       UART_DATA,
  output logic [7:0]       RX_STATUS
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Parity mismatch flag: the received parity bit, the data bits and the
  // odd/even sense must XOR to zero for a good frame.
  function automatic logic parity_err(input logic [7:0] data,
                                      input logic       par_bit,
                                      input logic       odd);
    return (^data) ^ par_bit ^ odd;
  endfunction

  // Synchroniser and receiver state
  logic             r_rx_meta;
  logic             r_rxs;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_div;
  logic             r_eight;
  logic             r_pen;
  logic             r_ohel;
  logic             r_stop2;
  logic [DIV_W-1:0] r_cnt;
  logic [3:0]       r_bit;
  logic [7:0]       r_data;
  logic             r_perr;
  logic             r_ferr;
  logic             r_stop_idx;

  logic [DIV_W-1:0] w_div_clamp;
  logic             w_go;
  logic             w_hit;
  logic             w_push;
  logic             w_last_bit;
  logic             w_ferr_fin;

  // FIFO state
  logic [9:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_ovf;

  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_wr;
  logic             w_ovf_set;
  logic             w_ovf_clr;
  logic [9:0]       w_head;

  assign w_last_bit = r_eight ? (r_bit == 4'd7) : (r_bit == 4'd6);
  assign w_ferr_fin = r_ferr | ~r_rxs;

  // Two-flop synchroniser for the asynchronous serial pin, idling high
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= RX;
      r_rxs     <= r_rx_meta;
    end
  end

  // Divisor clamp: anything below 4 clocks per bit runs at 4
  always_comb begin
    w_div_clamp = DIVISOR;
    if (DIVISOR < DIV_W'(3'd4)) begin
      w_div_clamp = DIV_W'(3'd4);
    end else begin
      w_div_clamp = DIVISOR;
    end
  end

  // Sample strobe: half a bit into the start bit, then every full bit
  always_comb begin
    w_hit = 1'b0;
    case (r_state)
      S_START:                  w_hit = (r_cnt == (r_div >> 1));
      S_DATA, S_PARITY, S_STOP: w_hit = (r_cnt == r_div);
      default:                  w_hit = 1'b0;
    endcase
  end

  // Receiver state register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; the last stop sample pushes the frame and returns to
  // IDLE in the same cycle so a back-to-back start is not missed
  always_comb begin
    w_state_nxt = r_state;
    w_go        = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rxs) begin
          w_state_nxt = S_START;
          w_go        = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (w_hit) begin
          if (r_rxs) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DATA;
          end
        end else begin
          w_state_nxt = S_START;
        end
      end
      S_DATA: begin
        if (w_hit && w_last_bit) begin
          if (r_pen) begin
            w_state_nxt = S_PARITY;
          end else begin
            w_state_nxt = S_STOP;
          end
        end else begin
          w_state_nxt = S_DATA;
        end
      end
      S_PARITY: begin
        if (w_hit) begin
          w_state_nxt = S_STOP;
        end else begin
          w_state_nxt = S_PARITY;
        end
      end
      S_STOP: begin
        if (w_hit && (!r_stop2 || r_stop_idx)) begin
          w_push      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_STOP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Frame datapath: configuration latch, bit timer, shift-in and error flags
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_div      <= '0;
      r_eight    <= 1'b0;
      r_pen      <= 1'b0;
      r_ohel     <= 1'b0;
      r_stop2    <= 1'b0;
      r_cnt      <= '0;
      r_bit      <= 4'd0;
      r_data     <= 8'h00;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_stop_idx <= 1'b0;
    end else if (w_go) begin
      r_div      <= w_div_clamp;
      r_eight    <= EIGHT;
      r_pen      <= PEN;
      r_ohel     <= OHEL;
      r_stop2    <= STOP2;
      r_cnt      <= DIV_W'(1'b1);
      r_bit      <= 4'd0;
      r_data     <= 8'h00;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_stop_idx <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        r_cnt <= '0;
      end else if (w_hit) begin
        r_cnt <= DIV_W'(1'b1);
      end else begin
        r_cnt <= r_cnt + DIV_W'(1'b1);
      end
      if (w_hit) begin
        case (r_state)
          S_DATA: begin
            r_data[r_bit[2:0]] <= r_rxs;
            r_bit              <= r_bit + 4'd1;
          end
          S_PARITY: begin
            r_perr <= parity_err(r_data, r_rxs, r_ohel);
          end
          S_STOP: begin
            r_ferr     <= w_ferr_fin;
            r_stop_idx <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // FIFO control: a push into a full FIFO only succeeds if a pop frees a slot
  always_comb begin
    w_empty   = (r_count == CW'(1'b0));
    w_full    = (r_count == CW'(FIFO_DEPTH));
    w_pop     = read_strobe & (port_id == 4'd0) & ~w_empty;
    w_wr      = w_push & (~w_full | w_pop);
    w_ovf_set = w_push & w_full & ~w_pop;
    w_ovf_clr = read_strobe & (port_id == 4'd1);
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge CLK) begin
    if (w_wr) begin
      r_mem[r_wptr] <= {w_ferr_fin, r_perr, r_data};
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag (set beats clear)
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + AW'(1'b1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1'b1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1'b1);
        2'b01:   r_count <= r_count - CW'(1'b1);
        default: r_count <= r_count;
      endcase
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // CPU-visible head entry and status; blank when the FIFO is empty
  always_comb begin
    w_head = r_mem[r_rptr];
    if (w_empty) begin
      UART_DATA = 8'h00;
      RX_STATUS = {3'b000, w_full, r_ovf, 1'b0, 1'b0, 1'b0};
    end else begin
      UART_DATA = w_head[7:0];
      RX_STATUS = {3'b000, w_full, r_ovf, w_head[9], w_head[8], 1'b1};
    end
  end

endmodule
